// File: rtl/onchip_mem_arb_pkg.sv
// onchip_mem_arb_pkg: shared defaults and types for the two-master on-chip RAM arbiter.
package onchip_mem_arb_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_id_t;

    typedef struct packed {
        logic       valid;
        master_id_t id;
    } rd_tag_t;

    function automatic master_id_t other(input master_id_t m);
        return (m == M0) ? M1 : M0;
    endfunction

endpackage

// File: rtl/onchip_mem_arb_rdpipe.sv
// onchip_mem_arb_rdpipe: READ_LATENCY-deep tag shift register that steers readdatavalid
// back to the master that issued each read.
module onchip_mem_arb_rdpipe
    import onchip_mem_arb_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic    clk,
    input  logic    reset_n,
    input  rd_tag_t tag_in,
    output logic    m0_valid,
    output logic    m1_valid
);

    rd_tag_t pipe [READ_LATENCY];

    // Async reset flushes in-flight tags so no response escapes after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= tag_in;
            for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign m0_valid = pipe[READ_LATENCY-1].valid && pipe[READ_LATENCY-1].id == M0;
    assign m1_valid = pipe[READ_LATENCY-1].valid && pipe[READ_LATENCY-1].id == M1;

endmodule

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: round-robin Avalon-MM arbiter sharing one single-port RAM between
// m0 and m1; define ONCHIP_ARB_LOCK_EN to add m0_lock/m1_lock grant locking.
module onchip_mem_arbiter
    import onchip_mem_arb_pkg::*;
#(
    parameter  int ADDR_W       = ADDR_W_DEF,
    parameter  int DATA_W       = DATA_W_DEF,
    parameter  int READ_LATENCY = 1,
    localparam int BE_W         = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
`ifdef ONCHIP_ARB_LOCK_EN
    input  logic              m0_lock,
    input  logic              m1_lock,
`endif
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    logic       req0, req1, gnt_vld, sel1, hold;
    master_id_t gnt, last_grant, hold_id;
    rd_tag_t    tag_in;

    assign req0    = m0_read | m0_write;
    assign req1    = m1_read | m1_write;
    // Outputs are gated by reset_n so everything reads as cleared while reset is held.
    assign gnt_vld = reset_n && (req0 || req1);

`ifdef ONCHIP_ARB_LOCK_EN
    logic       lock_vld;
    master_id_t lock_id;

    assign hold    = lock_vld && (lock_id == M0 ? req0 && m0_lock : req1 && m1_lock);
    assign hold_id = lock_id;

    // Owner is recorded only on a granted cycle with lock high; idle or lock low releases it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_vld <= 1'b0;
            lock_id  <= M0;
        end else begin
            lock_vld <= gnt_vld && (gnt == M0 ? m0_lock : m1_lock);
            lock_id  <= gnt;
        end
    end
`else
    assign hold    = 1'b0;
    assign hold_id = M0;
`endif

    assign gnt  = (req0 && req1) ? (hold ? hold_id : other(last_grant)) : (req1 ? M1 : M0);
    assign sel1 = gnt == M1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_grant <= M1;
        else if (gnt_vld) last_grant <= gnt;
    end

    assign mem_chipselect = gnt_vld;
    assign mem_write      = gnt_vld && (sel1 ? m1_write : m0_write);
    assign mem_address    = gnt_vld ? (sel1 ? m1_address : m0_address) : '0;
    assign mem_byteenable = gnt_vld ? (sel1 ? m1_byteenable : m0_byteenable) : '0;
    assign mem_writedata  = gnt_vld ? (sel1 ? m1_writedata : m0_writedata) : '0;
    assign mem_clken      = 1'b1;

    assign m0_waitrequest = reset_n && req0 && sel1;
    assign m1_waitrequest = reset_n && req1 && !sel1;

    assign m0_readdata = reset_n ? mem_readdata : '0;
    assign m1_readdata = reset_n ? mem_readdata : '0;

    // Read+write together counts as a write, so only pure reads get a tag.
    assign tag_in = '{valid: gnt_vld && !mem_write, id: gnt};

    onchip_mem_arb_rdpipe #(.READ_LATENCY(READ_LATENCY)) u_rdpipe (
        .clk      (clk),
        .reset_n  (reset_n),
        .tag_in   (tag_in),
        .m0_valid (m0_readdatavalid),
        .m1_valid (m1_readdatavalid)
    );

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb_onchip_mem_arbiter: directed bench with a RAM model, a transaction-level reference
// model checked every cycle, and literal expectations for the key scenarios.
module tb_onchip_mem_arbiter;

    localparam int L = 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [12:0] m0_address, m1_address, mem_address;
    logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, mem_writedata;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata, mem_readdata;
    logic        mem_chipselect, mem_write, mem_clken;
`ifdef ONCHIP_ARB_LOCK_EN
    logic        m0_lock, m1_lock;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    onchip_mem_arbiter #(.ADDR_W(13), .DATA_W(32), .READ_LATENCY(L)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
`ifdef ONCHIP_ARB_LOCK_EN
        .m0_lock          (m0_lock),
        .m1_lock          (m1_lock),
`endif
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata)
    );

    // RAM behind the arbiter, plus an independent shadow image kept by the reference model.
    logic [31:0] ram    [8192];
    logic [31:0] shadow [8192];
    logic [31:0] rq1 = '0, rq2 = '0;

    initial for (int i = 0; i < 8192; i++) begin
        ram[i]    = 32'hC0DE0000 | i;
        shadow[i] = 32'hC0DE0000 | i;
    end

    always @(posedge clk) begin
        if (mem_chipselect && mem_write)
            for (int b = 0; b < 4; b++)
                if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        if (mem_chipselect && !mem_write) rq1 <= ram[mem_address];
        rq2 <= rq1;
    end
    assign mem_readdata = (L == 1) ? rq1 : rq2;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
        bit          chk;
    } rsp_t;

    rsp_t q[$];
    int   cyc   = 0;
    int   mlast = 1;
    int   mlo   = -1;
    int   pw_id = -1;
    int   pw_addr = 0;

    always @(negedge clk) begin : cmp
        int          g, ea, eid;
        bit          r0, r1, ev, ew;
        logic [3:0]  eb;
        logic [31:0] ed;
        #2;
        cyc++;
        if (!reset_n) begin
            chk("rst_m0_wait", m0_waitrequest, 0);
            chk("rst_m1_wait", m1_waitrequest, 0);
            chk("rst_m0_rdv", m0_readdatavalid, 0);
            chk("rst_m1_rdv", m1_readdatavalid, 0);
            chk("rst_m0_rdata", m0_readdata, 0);
            chk("rst_m1_rdata", m1_readdata, 0);
            chk("rst_mem_cs", mem_chipselect, 0);
            chk("rst_mem_wr", mem_write, 0);
            chk("rst_mem_addr", mem_address, 0);
            chk("rst_mem_be", mem_byteenable, 0);
            chk("rst_mem_wd", mem_writedata, 0);
            q.delete();
            mlast = 1;
            mlo   = -1;
            pw_id = -1;
        end else begin
            r0 = m0_read | m0_write;
            r1 = m1_read | m1_write;
            if (r0 && r1) g = 1 - mlast;
            else if (r0) g = 0;
            else if (r1) g = 1;
            else g = -1;
`ifdef ONCHIP_ARB_LOCK_EN
            if (mlo == 0 && r0 && m0_lock) g = 0;
            if (mlo == 1 && r1 && m1_lock) g = 1;
`endif
            chk("m0_wait", m0_waitrequest, r0 && g != 0);
            chk("m1_wait", m1_waitrequest, r1 && g != 1);
            chk("mem_cs", mem_chipselect, g >= 0);
            chk("mem_clken", mem_clken, 1);
            ew = 0;
            ea = 0;
            if (g >= 0) begin
                ew = (g == 1) ? m1_write : m0_write;
                ea = (g == 1) ? int'(m1_address) : int'(m0_address);
                eb = (g == 1) ? m1_byteenable : m0_byteenable;
                ed = (g == 1) ? m1_writedata : m0_writedata;
                chk("mem_write", mem_write, ew);
                chk("mem_addr", mem_address, ea);
                chk("mem_be", mem_byteenable, eb);
                chk("mem_wd", mem_writedata, ed);
            end else begin
                chk("mem_write_idle", mem_write, 0);
            end
            ev  = q.size() > 0 && q[0].due == cyc;
            eid = ev ? q[0].id : -1;
            chk("m0_rdv", m0_readdatavalid, eid == 0);
            chk("m1_rdv", m1_readdatavalid, eid == 1);
            if (ev) begin
                if (q[0].chk) begin
                    chk("m0_rdata", m0_readdata, q[0].data);
                    chk("m1_rdata", m1_readdata, q[0].data);
                end
                void'(q.pop_front());
            end
            if (g >= 0) begin
                mlast = g;
                if (ew) begin
                    for (int b = 0; b < 4; b++) if (eb[b]) shadow[ea][8*b +: 8] = ed[8*b +: 8];
                    pw_id   = g;
                    pw_addr = ea;
                end else begin
                    q.push_back('{cyc + L, g, shadow[ea], !(pw_id >= 0 && pw_id != g && pw_addr == ea)});
                    pw_id = -1;
                end
`ifdef ONCHIP_ARB_LOCK_EN
                mlo = ((g == 1) ? m1_lock : m0_lock) ? g : -1;
`endif
            end else begin
                pw_id = -1;
                mlo   = -1;
            end
        end
    end

    task automatic start();
        @(negedge clk);
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
`ifdef ONCHIP_ARB_LOCK_EN
        m0_lock = 0; m1_lock = 0;
`endif
    endtask

    task automatic s0(input bit rd, input bit wr, input logic [12:0] a, input logic [3:0] be, input logic [31:0] d);
        m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    endtask

    task automatic s1(input bit rd, input bit wr, input logic [12:0] a, input logic [3:0] be, input logic [31:0] d);
        m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 0;
        m0_read = 0; m0_write = 0; m0_address = 0; m0_byteenable = 0; m0_writedata = 0;
        m1_read = 0; m1_write = 0; m1_address = 0; m1_byteenable = 0; m1_writedata = 0;
`ifdef ONCHIP_ARB_LOCK_EN
        m0_lock = 0; m1_lock = 0;
`endif
        // Reset held with a pending m0 read request
        repeat (3) begin
            start(); s0(1, 0, 13'h0010, 4'hF, 0); #3;
            chk("lit_rst_wait", m0_waitrequest, 0);
            chk("lit_rst_cs", mem_chipselect, 0);
        end
        start(); reset_n = 1; s0(1, 0, 13'h0010, 4'hF, 0); #3;
        chk("lit_first_cs", mem_chipselect, 1);
        start(); #3;
        chk("lit_first_rdv", m0_readdatavalid, 1);
        chk("lit_first_rdata", m0_readdata, 32'hC0DE0010);
        start(); #3;
        chk("lit_first_rdv_once", m0_readdatavalid, 0);

        // m1 streaming writes then reads
        for (int i = 0; i < 4; i++) begin
            start(); s1(0, 1, 13'h0100 + 13'(i), 4'hF, 32'hA5A50001 + i); #3;
            chk("lit_stream_wait_w", m1_waitrequest, 0);
        end
        for (int i = 0; i < 5; i++) begin
            start();
            if (i < 4) s1(1, 0, 13'h0100 + 13'(i), 4'hF, 0);
            #3;
            chk("lit_stream_wait_r", m1_waitrequest, 0);
            if (i > 0) begin
                chk("lit_stream_rdv", m1_readdatavalid, 1);
                chk("lit_stream_rdata", m1_readdata, 32'hA5A50001 + i - 1);
            end
        end

        // Contention: both masters reading every cycle
        for (int k = 0; k < 7; k++) begin
            start();
            if (k < 6) begin
                s0(1, 0, 13'h0020, 4'hF, 0);
                s1(1, 0, 13'h0040, 4'hF, 0);
            end
            #3;
            if (k < 6) begin
                chk("lit_cont_m0_wait", m0_waitrequest, k % 2);
                chk("lit_cont_m1_wait", m1_waitrequest, (k + 1) % 2);
            end
            if (k > 0) begin
                chk("lit_cont_m0_rdv", m0_readdatavalid, (k - 1) % 2 == 0);
                chk("lit_cont_m1_rdv", m1_readdatavalid, (k - 1) % 2 == 1);
                chk("lit_cont_rdata", m0_readdata, ((k - 1) % 2 == 0) ? 32'hC0DE0020 : 32'hC0DE0040);
            end
        end

        // Byteenable merge
        start(); s0(0, 1, 13'h0080, 4'hF, 32'hFFFFFFFF);
        start(); s0(0, 1, 13'h0080, 4'b0101, 32'h00000000);
        start(); s0(1, 0, 13'h0080, 4'hF, 0);
        start(); #3;
        chk("lit_be_rdv", m0_readdatavalid, 1);
        chk("lit_be_rdata", m0_readdata, 32'hFF00FF00);

        // Read and write together is a write
        start(); s0(1, 1, 13'h0090, 4'hF, 32'h12345678); #3;
        chk("lit_rw_is_write", mem_write, 1);
        start(); s0(1, 0, 13'h0090, 4'hF, 0); #3;
        chk("lit_rw_no_rdv", m0_readdatavalid, 0);
        start(); #3;
        chk("lit_rw_rdata", m0_readdata, 32'h12345678);

        // Reset while an m1 read is outstanding
        start(); s1(1, 0, 13'h0040, 4'hF, 0);
        start(); reset_n = 0; #3;
        chk("lit_midrst_rdv", m1_readdatavalid, 0);
        start();
        start(); reset_n = 1;
        repeat (3) begin
            start(); #3;
            chk("lit_midrst_no_rdv", m1_readdatavalid, 0);
        end

        // last_grant must return to m1 on reset so m0 wins the next contention
        start(); s0(1, 0, 13'h0020, 4'hF, 0);
        start(); reset_n = 0;
        start(); reset_n = 1; s0(1, 0, 13'h0020, 4'hF, 0); s1(1, 0, 13'h0040, 4'hF, 0); #3;
        chk("lit_lg_m0_wait", m0_waitrequest, 0);
        chk("lit_lg_m1_wait", m1_waitrequest, 1);
        start(); s1(1, 0, 13'h0040, 4'hF, 0); #3;
        chk("lit_lg_m1_go", m1_waitrequest, 0);
        start();

`ifdef ONCHIP_ARB_LOCK_EN
        // m0 locked burst holds off m1
        start(); s1(0, 1, 13'h0200, 4'hF, 32'h0BADF00D);
        for (int k = 0; k < 3; k++) begin
            start(); s0(0, 1, 13'h0210 + 13'(k), 4'hF, 32'h10C00000 + k); m0_lock = 1;
            s1(1, 0, 13'h0040, 4'hF, 0); #3;
            chk("lit_lock_m0_wait", m0_waitrequest, 0);
            chk("lit_lock_m1_wait", m1_waitrequest, 1);
        end
        start(); s1(1, 0, 13'h0040, 4'hF, 0); #3;
        chk("lit_lock_m1_go", m1_waitrequest, 0);
        chk("lit_lock_addr", mem_address, 13'h0040);
        start(); #3;
        chk("lit_lock_rdv", m1_readdatavalid, 1);
`endif

        repeat (4) start();
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
